// File: rtl/channel_model_pkg.sv
// Shared channel-model constants: coded block geometry and sync-header codes.
package channel_model_pkg;

  localparam int unsigned NB_CODED_BLOCK = 66;
  localparam int unsigned NB_SH          = 2;

  localparam logic [NB_SH-1:0] SH_DATA = 2'b01;
  localparam logic [NB_SH-1:0] SH_CTRL = 2'b10;

  // Only the data and control codes are legal sync headers.
  function automatic logic sh_is_valid(input logic [NB_SH-1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/bit_error_popcount.sv
// Combinational population count of a WIDTH-bit error vector.
module bit_error_popcount #(
  parameter int unsigned WIDTH = 66,
  localparam int unsigned NB_OUT = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]  data,
  output logic [NB_OUT-1:0] count
);

  // Sum the set bits of the vector.
  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      count = count + NB_OUT'(data[i]);
    end
  end

endmodule

// File: rtl/channel_error_monitor.sv
// Channel error monitor: compares clean and error-injected coded blocks,
// accumulating block, bit, burst and (optionally) sync-header error statistics
// over snapshot windows.
// Optional feature: define CHANNEL_MON_SH_CHECK_EN to enable sync-header checking.
module channel_error_monitor #(
  parameter int unsigned NB_CODED_BLOCK = channel_model_pkg::NB_CODED_BLOCK,
  parameter int unsigned NB_COUNT       = 32,
  parameter int unsigned NB_BURST       = 16
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_valid,
  input  logic [NB_CODED_BLOCK-1:0] i_ref_data,
  input  logic [NB_CODED_BLOCK-1:0] i_rx_data,
  input  logic                      i_rf_clear,
  input  logic                      i_rf_snapshot,
  output logic                      o_err_flag,
  output logic [NB_COUNT-1:0]       o_block_err_count,
  output logic [NB_COUNT-1:0]       o_bit_err_count,
  output logic [NB_COUNT-1:0]       o_block_count,
  output logic [NB_BURST-1:0]       o_max_burst,
  output logic [NB_COUNT-1:0]       o_sh_err_count
);
  import channel_model_pkg::*;

  localparam int unsigned NB_PC  = $clog2(NB_CODED_BLOCK + 1);
  localparam int unsigned NB_SUM = ((NB_COUNT > NB_PC) ? NB_COUNT : NB_PC) + 1;

  function automatic logic [NB_COUNT-1:0] sat_inc_cnt(input logic [NB_COUNT-1:0] a);
    return (a == '1) ? a : a + NB_COUNT'(1);
  endfunction

  function automatic logic [NB_BURST-1:0] sat_inc_burst(input logic [NB_BURST-1:0] a);
    return (a == '1) ? a : a + NB_BURST'(1);
  endfunction

  function automatic logic [NB_COUNT-1:0] sat_add_cnt(input logic [NB_COUNT-1:0] a,
                                                      input logic [NB_PC-1:0]    b);
    logic [NB_SUM-1:0] sum;
    sum = NB_SUM'(a) + NB_SUM'(b);
    return (sum > NB_SUM'({NB_COUNT{1'b1}})) ? '1 : sum[NB_COUNT-1:0];
  endfunction

  logic [NB_CODED_BLOCK-1:0] diff_in;
  logic [NB_CODED_BLOCK-1:0] s1_diff;
  logic                      s1_valid;
  logic [NB_PC-1:0]          pc;

  logic                      blk_err;
  logic [NB_COUNT-1:0]       live_blocks, live_blk_err, live_bit_err;
  logic [NB_COUNT-1:0]       blocks_next, blk_err_next, bit_err_next;
  logic [NB_BURST-1:0]       run_len, live_max, run_next, max_next;

  // Raw difference; the sync header is excluded when it is checked separately.
  always_comb begin
    diff_in = i_ref_data ^ i_rx_data;
`ifdef CHANNEL_MON_SH_CHECK_EN
    diff_in[NB_CODED_BLOCK-1 -: NB_SH] = '0;
`endif
  end

  // Stage 1: register the difference vector with its valid bit.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      s1_valid <= 1'b0;
      s1_diff  <= '0;
    end else if (i_rf_clear) begin
      s1_valid <= 1'b0;
      s1_diff  <= '0;
    end else begin
      s1_valid <= i_valid;
      s1_diff  <= diff_in;
    end
  end

  bit_error_popcount #(.WIDTH(NB_CODED_BLOCK)) u_popcount (
    .data  (s1_diff),
    .count (pc)
  );

  // Stage 2: next values of the live statistics and burst tracker.
  always_comb begin
    blk_err      = s1_valid && (pc != '0);
    blocks_next  = live_blocks;
    blk_err_next = live_blk_err;
    bit_err_next = live_bit_err;
    run_next     = run_len;
    max_next     = live_max;
    if (s1_valid) begin
      blocks_next = sat_inc_cnt(live_blocks);
      if (blk_err) begin
        blk_err_next = sat_inc_cnt(live_blk_err);
        bit_err_next = sat_add_cnt(live_bit_err, pc);
        run_next     = sat_inc_burst(run_len);
      end else begin
        run_next = '0;
      end
      max_next = (run_next > live_max) ? run_next : live_max;
    end
  end

  // Live counters: restart on snapshot, but the current run carries over and
  // seeds the new window's maximum.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      live_blocks  <= '0;
      live_blk_err <= '0;
      live_bit_err <= '0;
      run_len      <= '0;
      live_max     <= '0;
    end else if (i_rf_clear) begin
      live_blocks  <= '0;
      live_blk_err <= '0;
      live_bit_err <= '0;
      run_len      <= '0;
      live_max     <= '0;
    end else if (i_rf_snapshot) begin
      live_blocks  <= '0;
      live_blk_err <= '0;
      live_bit_err <= '0;
      run_len      <= run_next;
      live_max     <= run_next;
    end else begin
      live_blocks  <= blocks_next;
      live_blk_err <= blk_err_next;
      live_bit_err <= bit_err_next;
      run_len      <= run_next;
      live_max     <= max_next;
    end
  end

  // Error flag and reported statistics (reported values move only on snapshot/clear).
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_err_flag        <= 1'b0;
      o_block_count     <= '0;
      o_block_err_count <= '0;
      o_bit_err_count   <= '0;
      o_max_burst       <= '0;
    end else if (i_rf_clear) begin
      o_err_flag        <= 1'b0;
      o_block_count     <= '0;
      o_block_err_count <= '0;
      o_bit_err_count   <= '0;
      o_max_burst       <= '0;
    end else begin
      o_err_flag <= blk_err;
      if (i_rf_snapshot) begin
        o_block_count     <= blocks_next;
        o_block_err_count <= blk_err_next;
        o_bit_err_count   <= bit_err_next;
        o_max_burst       <= max_next;
      end
    end
  end

`ifdef CHANNEL_MON_SH_CHECK_EN
  logic                s1_sh_bad;
  logic [NB_COUNT-1:0] live_sh_err, sh_next;

  assign sh_next = (s1_valid && s1_sh_bad) ? sat_inc_cnt(live_sh_err) : live_sh_err;

  // Sync-header errors follow the same window rules as the other counters.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      s1_sh_bad      <= 1'b0;
      live_sh_err    <= '0;
      o_sh_err_count <= '0;
    end else if (i_rf_clear) begin
      s1_sh_bad      <= 1'b0;
      live_sh_err    <= '0;
      o_sh_err_count <= '0;
    end else begin
      s1_sh_bad <= !sh_is_valid(i_rx_data[NB_CODED_BLOCK-1 -: NB_SH]);
      if (i_rf_snapshot) begin
        live_sh_err    <= '0;
        o_sh_err_count <= sh_next;
      end else begin
        live_sh_err <= sh_next;
      end
    end
  end
`else
  assign o_sh_err_count = '0;
`endif

endmodule

// File: tb/tb_channel_error_monitor.sv
// Self-checking bench for channel_error_monitor (NB_COUNT=8, NB_BURST=4 build
// so that counter and burst saturation are reachable).
module tb_channel_error_monitor;

  localparam int NB   = 66;
  localparam int NC   = 8;
  localparam int NBB  = 4;
  localparam longint CMAX = 255;
  localparam longint BMAX = 15;
`ifdef CHANNEL_MON_SH_CHECK_EN
  localparam longint PCW = 64;
`else
  localparam longint PCW = 66;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic          clr = 1'b0;
  logic          snap = 1'b0;
  logic [NB-1:0] refd = '0;
  logic [NB-1:0] rxd = '0;

  logic           o_err_flag;
  logic [NC-1:0]  o_block_err_count, o_bit_err_count, o_block_count, o_sh_err_count;
  logic [NBB-1:0] o_max_burst;

  always #5 clk = ~clk;

  channel_error_monitor #(
    .NB_CODED_BLOCK (NB),
    .NB_COUNT       (NC),
    .NB_BURST       (NBB)
  ) dut (
    .i_clock           (clk),
    .i_reset           (rst_n),
    .i_valid           (valid),
    .i_ref_data        (refd),
    .i_rx_data         (rxd),
    .i_rf_clear        (clr),
    .i_rf_snapshot     (snap),
    .o_err_flag        (o_err_flag),
    .o_block_err_count (o_block_err_count),
    .o_bit_err_count   (o_bit_err_count),
    .o_block_count     (o_block_count),
    .o_max_burst       (o_max_burst),
    .o_sh_err_count    (o_sh_err_count)
  );

  int errors = 0;
  int checks = 0;
  logic check_en = 1'b0;
  int flag_hi = 0;

  // Behavioural model: one in-flight block, live window totals, reported values.
  logic   m_s1_v = 1'b0;
  longint m_s1_pc = 0, m_s1_sh = 0;
  longint m_blocks = 0, m_blkerr = 0, m_biterr = 0, m_run = 0, m_max = 0, m_sh = 0;
  longint exp_flag = 0, exp_blocks = 0, exp_blkerr = 0, exp_biterr = 0, exp_max = 0, exp_sh = 0;

  function automatic longint lmin(longint a, longint b);
    return (a < b) ? a : b;
  endfunction

  function automatic longint pc_of(logic [NB-1:0] r, logic [NB-1:0] x);
    logic [NB-1:0] d;
    d = r ^ x;
`ifdef CHANNEL_MON_SH_CHECK_EN
    d[NB-1 -: 2] = 2'b00;
`endif
    return $countones(d);
  endfunction

  function automatic longint sh_bad(logic [NB-1:0] x);
`ifdef CHANNEL_MON_SH_CHECK_EN
    logic [1:0] h;
    h = x[NB-1 -: 2];
    return (h == 2'b00 || h == 2'b11) ? 1 : 0;
`else
    return (x == x) ? 0 : 0;
`endif
  endfunction

  function automatic logic [NB-1:0] rnd_block();
    logic [NB-1:0] b;
    b = {2'b01, $urandom(), $urandom()};
    return b;
  endfunction

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_s1_v = 1'b0; m_s1_pc = 0; m_s1_sh = 0;
    m_blocks = 0; m_blkerr = 0; m_biterr = 0; m_run = 0; m_max = 0; m_sh = 0;
    exp_flag = 0; exp_blocks = 0; exp_blkerr = 0; exp_biterr = 0; exp_max = 0; exp_sh = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    longint pc;
    if (!rst_n || clr) begin
      model_reset();
      return;
    end
    pc = m_s1_v ? m_s1_pc : 0;
    exp_flag = (pc > 0) ? 1 : 0;
    if (m_s1_v) begin
      m_blocks = lmin(m_blocks + 1, CMAX);
      if (pc > 0) begin
        m_blkerr = lmin(m_blkerr + 1, CMAX);
        m_biterr = lmin(m_biterr + pc, CMAX);
        m_run    = lmin(m_run + 1, BMAX);
      end else begin
        m_run = 0;
      end
      if (m_run > m_max) m_max = m_run;
      if (m_s1_sh != 0) m_sh = lmin(m_sh + 1, CMAX);
    end
    if (snap) begin
      exp_blocks = m_blocks; exp_blkerr = m_blkerr; exp_biterr = m_biterr;
      exp_max = m_max; exp_sh = m_sh;
      m_blocks = 0; m_blkerr = 0; m_biterr = 0; m_sh = 0;
      m_max = m_run;
    end
    m_s1_v  = valid;
    m_s1_pc = pc_of(refd, rxd);
    m_s1_sh = sh_bad(rxd);
  endtask

  task automatic step(input logic v, input logic [NB-1:0] r, input logic [NB-1:0] x,
                      input logic c, input logic s);
    @(negedge clk);
    valid = v; refd = r; rxd = x; clr = c; snap = s;
    model_edge();
    @(posedge clk);
  endtask

  task automatic clean_blk();
    logic [NB-1:0] r;
    r = rnd_block();
    step(1'b1, r, r, 1'b0, 1'b0);
  endtask

  task automatic err_blk();
    logic [NB-1:0] r, m;
    r = rnd_block();
    m = NB'(1) << $urandom_range(0, 63);
    step(1'b1, r, r ^ m, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic s);
    logic [NB-1:0] r;
    r = rnd_block();
    step(1'b0, r, ~r, 1'b0, s);
  endtask

  // Every cycle, compare all outputs with the model.
  always @(posedge clk) begin
    #1;
    if (o_err_flag) flag_hi++;
    if (check_en) begin
      check("err_flag", longint'(o_err_flag), exp_flag);
      check("block_count", longint'(o_block_count), exp_blocks);
      check("block_err_count", longint'(o_block_err_count), exp_blkerr);
      check("bit_err_count", longint'(o_bit_err_count), exp_biterr);
      check("max_burst", longint'(o_max_burst), exp_max);
      check("sh_err_count", longint'(o_sh_err_count), exp_sh);
    end
  end

  initial begin
    logic [NB-1:0] r, x, m;
    logic v, c, s;
    int kind, err_pct, snap_div;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_block_count", longint'(o_block_count), 0);
    check("reset_err_flag", longint'(o_err_flag), 0);
    check_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    model_edge();
    @(posedge clk);

    // 100 clean blocks then snapshot
    flag_hi = 0;
    repeat (100) clean_blk();
    idle(1'b1);
    #2;
    check("clean_block_count", longint'(o_block_count), 100);
    check("clean_block_err", longint'(o_block_err_count), 0);
    check("clean_bit_err", longint'(o_bit_err_count), 0);
    check("clean_max_burst", longint'(o_max_burst), 0);
    check("clean_flag_never", longint'(flag_hi), 0);

    // Single 2-bit error: flag exactly two cycles after input
    repeat (5) clean_blk();
    r = rnd_block();
    m = NB'(3);
    step(1'b1, r, r ^ m, 1'b0, 1'b0);
    #2 check("flag_at_n+1", longint'(o_err_flag), 0);
    idle(1'b0);
    #2 check("flag_at_n+2", longint'(o_err_flag), 1);
    idle(1'b0);
    #2 check("flag_at_n+3", longint'(o_err_flag), 0);
    idle(1'b1);
    #2;
    check("single_block_err", longint'(o_block_err_count), 1);
    check("single_bit_err", longint'(o_bit_err_count), 2);
    check("single_block_count", longint'(o_block_count), 6);

    // Bursts 3, 7 (with invalid gaps), 5
    repeat (3) err_blk();
    clean_blk();
    repeat (4) err_blk();
    idle(1'b0); idle(1'b0);
    repeat (3) err_blk();
    clean_blk();
    repeat (5) err_blk();
    clean_blk();
    idle(1'b1);
    #2;
    check("burst_max", longint'(o_max_burst), 7);
    check("burst_block_err", longint'(o_block_err_count), 15);

    // Bit error saturation
    repeat (3) begin r = rnd_block(); step(1'b1, r, ~r, 1'b0, 1'b0); end
    repeat (2) begin r = rnd_block(); step(1'b1, r, ~r, 1'b0, 1'b0); end
    clean_blk();
    idle(1'b1);
    #2;
    check("sat_bit_err", longint'(o_bit_err_count), (5 * PCW > CMAX) ? CMAX : 5 * PCW);
    check("sat_block_err", longint'(o_block_err_count), 5);

    // Clear and snapshot together with errors in flight
    err_blk(); err_blk();
    step(1'b0, '0, '0, 1'b1, 1'b1);
    #2;
    check("clr_flag", longint'(o_err_flag), 0);
    check("clr_block_count", longint'(o_block_count), 0);
    check("clr_block_err", longint'(o_block_err_count), 0);
    check("clr_bit_err", longint'(o_bit_err_count), 0);
    check("clr_max_burst", longint'(o_max_burst), 0);
    repeat (3) clean_blk();
    idle(1'b1);
    #2;
    check("post_clr_blocks", longint'(o_block_count), 3);
    check("post_clr_block_err", longint'(o_block_err_count), 0);
    check("post_clr_max", longint'(o_max_burst), 0);

    // Reset mid-operation discards in-flight blocks
    err_blk(); err_blk();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("areset_flag", longint'(o_err_flag), 0);
    check("areset_block_count", longint'(o_block_count), 0);
    check("areset_bit_err", longint'(o_bit_err_count), 0);
    err_blk();
    @(negedge clk);
    rst_n = 1'b1; valid = 1'b0; clr = 1'b0; snap = 1'b0;
    model_edge();
    @(posedge clk);
    repeat (2) clean_blk();
    idle(1'b1);
    #2;
    check("post_reset_blocks", longint'(o_block_count), 2);
    check("post_reset_block_err", longint'(o_block_err_count), 0);

`ifdef CHANNEL_MON_SH_CHECK_EN
    // Invalid sync headers with identical payloads
    repeat (4) begin
      r = rnd_block();
      x = r;
      x[NB-1 -: 2] = 2'b11;
      step(1'b1, r, x, 1'b0, 1'b0);
    end
    idle(1'b0);
    idle(1'b1);
    #2;
    check("sh_err_count", longint'(o_sh_err_count), 4);
    check("sh_bit_err", longint'(o_bit_err_count), 0);
`endif

    // Randomized phases: varying error density and snapshot rate
    for (int ph = 0; ph < 4; ph++) begin
      err_pct  = (ph == 1) ? 95 : (ph == 3 ? 60 : 25);
      snap_div = (ph == 2) ? 600 : 25;
      for (int i = 0; i < 1000; i++) begin
        v = ($urandom_range(0, 3) != 0);
        r = rnd_block();
        x = r;
        kind = int'($urandom_range(0, 99));
        if (kind < err_pct) begin
          if ($urandom_range(0, 3) == 0) x = r ^ {$urandom(), $urandom(), $urandom()};
          else x = r ^ (NB'(1) << $urandom_range(0, NB - 1));
        end
        if ($urandom_range(0, 9) == 0) x[NB-1 -: 2] = 2'($urandom_range(0, 3));
        c = ($urandom_range(0, 299) == 0);
        s = ($urandom_range(0, snap_div - 1) == 0);
        step(v, r, x, c, s);
      end
    end
    idle(1'b0);
    idle(1'b1);
    #2;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
